// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Owns the fetch PC, reads instructions
//            over the shared bus (req/grant/strobe/ready handshake) and
//            registers the IF/ID outputs for the decoder. Applies decoder
//            branch redirects with one delay slot, honours stall and flush
//            from the pipeline controller, and reports busy while a fetch is
//            outstanding.
// Ports    : clk, reset_ (async, active-low)
//            stall, flush, new_pc          - pipeline controller
//            br_taken, br_addr             - decoder branch redirect
//            bus_req_, bus_grnt_, bus_as_, bus_rw, bus_addr,
//            bus_rd_data, bus_rdy_         - shared bus master
//            if_pc, if_insn, if_en         - IF/ID pipeline register
//            busy                          - fetch outstanding
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [29:0] RESET_VECTOR = 30'h0
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_started;    // low for the first edge after reset release
  logic [29:0] r_fetch_pc;
  logic [29:0] r_bus_addr;
  logic [31:0] r_hold_insn;
  logic        r_kill;       // outstanding transfer belongs to a flushed stream
  logic [29:0] r_if_pc;
  logic [31:0] r_if_insn;
  logic        r_if_en;

  logic        w_insn_valid;
  logic [31:0] w_fetch_data;
  logic        w_adv;
  logic [29:0] w_next_pc;
  logic        w_baddr_ld;
  logic        w_hold_ld;
  logic        w_kill_set;
  logic        w_kill_clr;

  // --------------------------------------------------------------------------
  // Instruction availability and PC update
  // --------------------------------------------------------------------------
  assign w_insn_valid = ((r_state == ST_ACCESS) && !bus_rdy_ && !r_kill) ||
                        (r_state == ST_HOLD);
  assign w_fetch_data = (r_state == ST_HOLD) ? r_hold_insn : bus_rd_data;
  assign w_adv        = w_insn_valid && !stall && !flush;

  // The instruction delivered while a taken branch sits in IF/ID is the
  // delay slot; the redirect only affects the fetch after it.
  always_comb begin
    w_next_pc = r_fetch_pc;
    if (flush) begin
      w_next_pc = new_pc;
    end else if (w_adv) begin
      w_next_pc = (r_if_en && br_taken) ? br_addr : (r_fetch_pc + 30'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Bus state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baddr_ld  = 1'b0;
    w_hold_ld   = 1'b0;
    w_kill_set  = 1'b0;
    w_kill_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_started) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!bus_grnt_) begin
          w_state_nxt = ST_ACCESS;
          w_baddr_ld  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (bus_rdy_) begin
          // A transfer cannot be aborted; mark it so its data is dropped.
          if (flush) begin
            w_kill_set = 1'b1;
          end
        end else if (r_kill || flush) begin
          w_kill_clr = 1'b1;
          w_baddr_ld = 1'b1;
        end else if (w_adv) begin
          w_baddr_ld = 1'b1;
        end else begin
          // Data is valid but the pipeline is stalled: park it and free
          // the bus rather than holding the arbiter.
          w_hold_ld   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush || w_adv) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_started   <= 1'b0;
      r_fetch_pc  <= RESET_VECTOR;
      r_bus_addr  <= RESET_VECTOR;
      r_hold_insn <= 32'h0;
      r_kill      <= 1'b0;
      r_if_pc     <= RESET_VECTOR;
      r_if_insn   <= 32'h0;
      r_if_en     <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_fetch_pc <= w_next_pc;

      if (w_baddr_ld) begin
        r_bus_addr <= w_next_pc;
      end

      if (w_hold_ld) begin
        r_hold_insn <= bus_rd_data;
      end

      if (w_kill_set) begin
        r_kill <= 1'b1;
      end else if (w_kill_clr) begin
        r_kill <= 1'b0;
      end

      if (flush) begin
        r_if_pc   <= new_pc;
        r_if_insn <= 32'h0;
        r_if_en   <= 1'b0;
      end else if (w_adv) begin
        r_if_pc   <= r_fetch_pc;
        r_if_insn <= w_fetch_data;
        r_if_en   <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus_req_ = !((r_state == ST_REQ) || (r_state == ST_ACCESS));
  assign bus_as_  = !(r_state == ST_ACCESS);
  assign bus_rw   = 1'b1;
  assign bus_addr = r_bus_addr;
  assign if_pc    = r_if_pc;
  assign if_insn  = r_if_insn;
  assign if_en    = r_if_en;

  // Deliberately independent of stall so the controller can use it without
  // forming a combinational loop.
  assign busy = (r_state == ST_IDLE) || (r_state == ST_REQ) ||
                ((r_state == ST_ACCESS) && !(!bus_rdy_ && !r_kill));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A zero-wait memory returns
//            {2'b0, bus_addr}; the grant follows the request immediately.
//            A vector table drives stall/flush/branch/wait inputs per cycle
//            and lists the expected outputs; a few hand-written sequences
//            cover reset state, asynchronous reset mid-transfer and the
//            single bus read of a stalled instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        reset_;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        bus_req_;
  logic        bus_grnt_;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;
  logic        busy;

  logic        wt;        // insert a wait cycle on the current access
  int          total;
  int          bad;
  int          reads5;

  fetch_stage #(.RESET_VECTOR(30'h0)) dut (
    .clk         (clk),
    .reset_      (reset_),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en),
    .busy        (busy)
  );

  // Bus environment: immediate grant, memory content = word address.
  assign bus_grnt_   = bus_req_;
  assign bus_rdy_    = bus_as_ | wt;
  assign bus_rd_data = {2'b00, bus_addr};

  always #5 clk = ~clk;

  // Count completed reads of word address 5.
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      reads5 <= 0;
    end else if (!bus_as_ && !bus_rdy_ && (bus_addr == 30'd5)) begin
      reads5 <= reads5 + 1;
    end
  end

  typedef struct packed {
    logic        st;
    logic        fl;
    logic [29:0] npc;
    logic        bt;
    logic [29:0] ba;
    logic        w;
    logic        e_busy;   // sampled before the edge
    logic        e_en;     // the rest sampled after the edge
    logic [29:0] e_pc;
    logic [31:0] e_insn;
    logic [29:0] e_baddr;
    logic        e_req;
    logic        e_as;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic st, input logic fl, input logic [29:0] npc,
                      input logic bt, input logic [29:0] ba, input logic w,
                      input logic e_busy, input logic e_en,
                      input logic [29:0] e_pc, input logic [31:0] e_insn,
                      input logic [29:0] e_baddr, input logic e_req,
                      input logic e_as);
    vec_t v;
    v.st = st; v.fl = fl; v.npc = npc; v.bt = bt; v.ba = ba; v.w = w;
    v.e_busy = e_busy; v.e_en = e_en; v.e_pc = e_pc; v.e_insn = e_insn;
    v.e_baddr = e_baddr; v.e_req = e_req; v.e_as = e_as;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset_   = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    new_pc   = 30'h0;
    br_taken = 1'b0;
    br_addr  = 30'h0;
    wt       = 1'b0;
    total    = 0;
    bad      = 0;

    //     st fl npc        bt ba          w  | busy en pc         insn         baddr      req as
    addv(0, 0, 30'h0,     0, 30'h0,     0,   1,  0, 30'h0,     32'h0,       30'h0,     1, 1); // edge1: IDLE
    addv(0, 0, 30'h0,     0, 30'h0,     0,   1,  0, 30'h0,     32'h0,       30'h0,     0, 1); // edge2: REQ
    addv(0, 0, 30'h0,     0, 30'h0,     0,   1,  0, 30'h0,     32'h0,       30'h0,     0, 0); // edge3: ACCESS
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h0,     32'h0,       30'h1,     0, 0); // edge4: first insn
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h1,     32'h1,       30'h2,     0, 0);
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h2,     32'h2,       30'h3,     0, 0);
    addv(0, 0, 30'h0,     0, 30'h0,     1,   1,  1, 30'h2,     32'h2,       30'h3,     0, 0); // wait 1 on 3
    addv(0, 0, 30'h0,     0, 30'h0,     1,   1,  1, 30'h2,     32'h2,       30'h3,     0, 0); // wait 2 on 3
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h3,     32'h3,       30'h4,     0, 0);
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h4,     32'h4,       30'h5,     0, 0);
    addv(1, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h4,     32'h4,       30'h5,     1, 1); // stall -> HOLD
    addv(1, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h4,     32'h4,       30'h5,     1, 1);
    addv(1, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h4,     32'h4,       30'h5,     1, 1);
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h5,     32'h5,       30'h5,     0, 1); // held insn, REQ
    addv(0, 0, 30'h0,     0, 30'h0,     0,   1,  1, 30'h5,     32'h5,       30'h6,     0, 0); // ACCESS 6
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h6,     32'h6,       30'h7,     0, 0);
    addv(0, 0, 30'h0,     1, 30'h40,    0,   0,  1, 30'h7,     32'h7,       30'h40,    0, 0); // branch, slot 7
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h40,    32'h40,      30'h41,    0, 0);
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h41,    32'h41,      30'h42,    0, 0);
    addv(0, 1, 30'h100,   0, 30'h0,     1,   1,  0, 30'h100,   32'h0,       30'h42,    0, 0); // flush while waiting
    addv(0, 0, 30'h0,     0, 30'h0,     0,   1,  0, 30'h100,   32'h0,       30'h100,   0, 0); // killed data dropped
    addv(0, 0, 30'h0,     1, 30'h200,   0,   0,  1, 30'h100,   32'h100,     30'h101,   0, 0); // br with if_en=0 ignored
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h101,   32'h101,     30'h102,   0, 0);
    addv(0, 1, 30'h300,   0, 30'h0,     0,   0,  0, 30'h300,   32'h0,       30'h300,   0, 0); // flush + rdy
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h300,   32'h300,     30'h301,   0, 0);
    addv(1, 1, 30'h10,    0, 30'h0,     0,   0,  0, 30'h10,    32'h0,       30'h10,    0, 0); // flush beats stall
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h10,    32'h10,      30'h11,    0, 0);
    addv(1, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h10,    32'h10,      30'h11,    1, 1); // HOLD
    addv(1, 1, 30'h20,    0, 30'h0,     0,   0,  0, 30'h20,    32'h0,       30'h11,    0, 1); // flush from HOLD
    addv(0, 0, 30'h0,     0, 30'h0,     0,   1,  0, 30'h20,    32'h0,       30'h20,    0, 0);
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h20,    32'h20,      30'h21,    0, 0);
    addv(0, 0, 30'h0,     1, 30'h3FFFFFFF, 0, 0, 1, 30'h21,    32'h21,      30'h3FFFFFFF, 0, 0);
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h3FFFFFFF, 32'h3FFFFFFF, 30'h0,  0, 0); // PC wraps
    addv(0, 0, 30'h0,     0, 30'h0,     0,   0,  1, 30'h0,     32'h0,       30'h1,     0, 0);

    // Reset state while reset_ is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  -1, {31'b0, busy},     32'h1);
    chk("rst_req",   -1, {31'b0, bus_req_}, 32'h1);
    chk("rst_as",    -1, {31'b0, bus_as_},  32'h1);
    chk("rst_en",    -1, {31'b0, if_en},    32'h0);
    chk("rst_pc",    -1, {2'b0, if_pc},     32'h0);
    chk("rst_insn",  -1, if_insn,           32'h0);
    chk("rst_baddr", -1, {2'b0, bus_addr},  32'h0);
    chk("rst_rw",    -1, {31'b0, bus_rw},   32'h1);

    @(negedge clk);
    reset_ = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall    = vecs[i].st;
      flush    = vecs[i].fl;
      new_pc   = vecs[i].npc;
      br_taken = vecs[i].bt;
      br_addr  = vecs[i].ba;
      wt       = vecs[i].w;
      #1;
      chk("busy", i, {31'b0, busy}, {31'b0, vecs[i].e_busy});
      @(posedge clk);
      #1;
      chk("if_en",    i, {31'b0, if_en},    {31'b0, vecs[i].e_en});
      chk("if_pc",    i, {2'b0, if_pc},     {2'b0, vecs[i].e_pc});
      chk("if_insn",  i, if_insn,           vecs[i].e_insn);
      chk("bus_addr", i, {2'b0, bus_addr},  {2'b0, vecs[i].e_baddr});
      chk("bus_req_", i, {31'b0, bus_req_}, {31'b0, vecs[i].e_req});
      chk("bus_as_",  i, {31'b0, bus_as_},  {31'b0, vecs[i].e_as});
    end

    // The stalled instruction at 5 was read from the bus exactly once.
    chk("reads_of_5", -1, reads5, 32'd1);

    // Asynchronous reset in the middle of a waiting ACCESS.
    @(negedge clk);
    stall    = 1'b0;
    flush    = 1'b0;
    br_taken = 1'b0;
    wt       = 1'b1;
    #1;
    chk("pre_rst_as", -1, {31'b0, bus_as_}, 32'h0);
    #1;
    reset_ = 1'b0;
    #1;
    chk("arst_req",   -1, {31'b0, bus_req_}, 32'h1);
    chk("arst_as",    -1, {31'b0, bus_as_},  32'h1);
    chk("arst_en",    -1, {31'b0, if_en},    32'h0);
    chk("arst_pc",    -1, {2'b0, if_pc},     32'h0);
    chk("arst_baddr", -1, {2'b0, bus_addr},  32'h0);
    chk("arst_busy",  -1, {31'b0, busy},     32'h1);

    @(negedge clk);
    reset_ = 1'b1;
    wt     = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
